// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: owner codes, arbiter state encodings and active-low enable levels.
package bus_arbiter_pkg;

  localparam int BUS_OWNER_W = 2;
  typedef logic [BUS_OWNER_W-1:0] owner_t;

  localparam owner_t BUS_OWNER_M0 = 2'd0;
  localparam owner_t BUS_OWNER_M1 = 2'd1;
  localparam owner_t BUS_OWNER_M2 = 2'd2;
  localparam owner_t BUS_OWNER_M3 = 2'd3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  function automatic logic [3:0] owner_onehot(owner_t o);
    owner_onehot = 4'b0001 << o;
  endfunction

  // Active-low grant vector with only the given owner enabled.
  function automatic logic [3:0] grant_vec(owner_t o);
    grant_vec    = {4{DISABLE_}};
    grant_vec[o] = ENABLE_;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-side view of the shared bus: active-low requests, muxed strobe, active-low grants.
interface bus_arbiter_if;

  logic m0_req_;
  logic m1_req_;
  logic m2_req_;
  logic m3_req_;
  logic s_as_;
  logic m0_grnt_;
  logic m1_grnt_;
  logic m2_grnt_;
  logic m3_grnt_;
  logic bus_busy;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_busy
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_busy
  );

endinterface

// File: rtl/bus_arbiter_rr_pick4.sv
// Combinational 4-way round-robin pick: first active-high request at or after start_i (mod 4).
module rr_pick4
  import bus_arbiter_pkg::*;
(
  input  logic [3:0] req_i,
  input  owner_t     start_i,
  output owner_t     idx_o,
  output logic       vld_o
);

  owner_t cand;

  always_comb begin
    idx_o = start_i;
    vld_o = 1'b0;
    cand  = start_i;
    for (int k = 0; k < 4; k++) begin
      cand = start_i + owner_t'(k);
      if (!vld_o && req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants and
// hold-limit preemption that only fires between bus cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic [3:0]       req_vec;
  arb_state_e       state_q;
  owner_t           owner_q;
  owner_t           last_owner_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [3:0]       grnt_q;
  logic             bus_busy_q;

  owner_t           pick_start;
  logic [3:0]       pick_req;
  owner_t           pick_idx;
  logic             pick_vld;
  logic             preempt_ok;

  assign req_vec = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // While granted the owner is masked out, so pick_vld also means "someone else wants the bus".
  always_comb begin
    if (state_q == ARB_GRANT) begin
      pick_start = owner_q + owner_t'(1);
      pick_req   = req_vec & ~owner_onehot(owner_q);
    end else begin
      pick_start = last_owner_q + owner_t'(1);
      pick_req   = req_vec;
    end
  end

  rr_pick4 u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  assign hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
  assign preempt_ok = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) &&
                      (bus.s_as_ == 1'b1) && pick_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= BUS_OWNER_M0;
      last_owner_q <= BUS_OWNER_M3;
      hold_cnt_q   <= '0;
      grnt_q       <= {4{DISABLE_}};
      bus_busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            state_q    <= ARB_GRANT;
            owner_q    <= pick_idx;
            hold_cnt_q <= '0;
            grnt_q     <= grant_vec(pick_idx);
            bus_busy_q <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!req_vec[owner_q]) begin
            last_owner_q <= owner_q;
            hold_cnt_q   <= '0;
            if (pick_vld) begin
              owner_q <= pick_idx;
              grnt_q  <= grant_vec(pick_idx);
            end else begin
              state_q    <= ARB_IDLE;
              grnt_q     <= {4{DISABLE_}};
              bus_busy_q <= 1'b0;
            end
          end else if (preempt_ok) begin
            last_owner_q <= owner_q;
            owner_q      <= pick_idx;
            hold_cnt_q   <= '0;
            grnt_q       <= grant_vec(pick_idx);
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          grnt_q     <= {4{DISABLE_}};
          bus_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.bus_busy = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a
// queue-free behavioural model of the round-robin/preemption rules.
module tb_bus_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       as_n;

  bus_arbiter_if bif ();
  assign bif.m0_req_ = req_n[0];
  assign bif.m1_req_ = req_n[1];
  assign bif.m2_req_ = req_n[2];
  assign bif.m3_req_ = req_n[3];
  assign bif.s_as_   = as_n;

  bus_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: owner index or -1 when nobody holds the bus; m_cnt counts edges since the grant.
  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;

  function automatic logic [3:0] got_grnt();
    return {bif.m3_grnt_, bif.m2_grnt_, bif.m1_grnt_, bif.m0_grnt_};
  endfunction

  function automatic logic [3:0] exp_grnt();
    logic [3:0] g;
    g = 4'hF;
    if (m_owner >= 0) g[m_owner] = 1'b0;
    return g;
  endfunction

  function automatic int rr_find(int start, int excl, logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic int decode_owner(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] r;
    int nxt;
    r = ~req_n;
    if (reset) begin
      m_owner = -1; m_last = 3; m_cnt = 0;
    end else if (m_owner < 0) begin
      nxt = rr_find(m_last + 1, -1, r);
      if (nxt >= 0) begin m_owner = nxt; m_cnt = 0; end
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = rr_find(m_owner + 1, m_owner, r);
      m_cnt   = 0;
    end else begin
      nxt = rr_find(m_owner + 1, m_owner, r);
      if (MAXH != 0 && m_cnt >= MAXH && as_n && nxt >= 0) begin
        m_last = m_owner; m_owner = nxt; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_n = 4'hF; as_n = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_n = 4'hF; as_n = 1'b1;
    tick(); tick();
    total++;
    if (got_grnt() !== 4'hF) begin bad++; $display("FAIL reset_grnt got=%b exp=1111", got_grnt()); end
    total++;
    if (bif.bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bif.bus_busy); end
    reset = 1'b0;
    tick(); tick();
    total++;
    if (got_grnt() !== 4'hF) begin bad++; $display("FAIL idle_grnt got=%b exp=1111", got_grnt()); end
    req_n[2] = 1'b0;
    tick();
    total++;
    if (got_grnt() !== 4'b1011) begin bad++; $display("FAIL m2_first_grant got=%b exp=1011", got_grnt()); end
    total++;
    if (bif.bus_busy !== 1'b1) begin bad++; $display("FAIL m2_busy got=%b exp=1", bif.bus_busy); end
  endtask

  task automatic test_round_robin();
    int seq[$];
    int prev, held, o;
    do_reset();
    req_n = 4'h0;
    prev = -1; held = 0;
    for (int cyc = 0; cyc < 40 && seq.size() < 5; cyc++) begin
      tick();
      total++;
      if ($countones(~got_grnt()) != 1) begin
        bad++; $display("FAIL rr_one_grant cyc=%0d got=%b exp=one low", cyc, got_grnt());
      end
      o = decode_owner(got_grnt());
      if (o != prev) begin seq.push_back(o); held = 1; prev = o; end
      else held++;
      req_n = 4'h0;
      if (o >= 0 && held >= 3) req_n[o] = 1'b1;
    end
    total++;
    if (seq.size() != 5) begin bad++; $display("FAIL rr_seq_len got=%0d exp=5", seq.size()); end
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      total++;
      if (seq[i] != i % 4) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, seq[i], i % 4); end
    end
  endtask

  task automatic test_preempt();
    int held;
    do_reset();
    req_n = 4'b1110; as_n = 1'b1;
    tick();
    total++;
    if (got_grnt() !== 4'b1110) begin bad++; $display("FAIL pre_m0_grant got=%b exp=1110", got_grnt()); end
    req_n = 4'b1100;
    held = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (got_grnt() !== 4'b1110) break;
      held++;
    end
    total++;
    if (held != MAXH + 1) begin bad++; $display("FAIL pre_hold_cycles got=%0d exp=%0d", held, MAXH + 1); end
    total++;
    if (got_grnt() !== 4'b1101) begin bad++; $display("FAIL pre_m1_grant got=%b exp=1101", got_grnt()); end
  endtask

  task automatic test_preempt_blocked();
    do_reset();
    req_n = 4'b1110; as_n = 1'b0;
    tick();
    req_n = 4'b1100;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      total++;
      if (got_grnt() !== 4'b1110) begin bad++; $display("FAIL blk_hold cyc=%0d got=%b exp=1110", cyc, got_grnt()); end
    end
    as_n = 1'b1;
    tick();
    total++;
    if (got_grnt() !== 4'b1101) begin bad++; $display("FAIL blk_release got=%b exp=1101", got_grnt()); end
  endtask

  task automatic test_sole_owner();
    do_reset();
    req_n = 4'b0111; as_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      total++;
      if (got_grnt() !== 4'b0111) begin bad++; $display("FAIL sole_hold cyc=%0d got=%b exp=0111", cyc, got_grnt()); end
    end
    // A saturated hold counter means the very next edge hands over.
    req_n = 4'b0110;
    tick();
    total++;
    if (got_grnt() !== 4'b1110) begin bad++; $display("FAIL sole_sat_preempt got=%b exp=1110", got_grnt()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_n = 4'b1101; as_n = 1'b0;
    tick();
    total++;
    if (got_grnt() !== 4'b1101) begin bad++; $display("FAIL mid_m1_grant got=%b exp=1101", got_grnt()); end
    reset = 1'b1;
    tick();
    total++;
    if (got_grnt() !== 4'hF) begin bad++; $display("FAIL mid_reset_grnt got=%b exp=1111", got_grnt()); end
    total++;
    if (bif.bus_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", bif.bus_busy); end
    reset = 1'b0; req_n = 4'b1100; as_n = 1'b1;
    tick();
    total++;
    if (got_grnt() !== 4'b1110) begin bad++; $display("FAIL mid_m0_first got=%b exp=1110", got_grnt()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 3) == 0) req_n = 4'($urandom_range(0, 15));
      as_n  = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      total++;
      if (got_grnt() !== exp_grnt()) begin
        bad++; $display("FAIL rnd_grnt cyc=%0d got=%b exp=%b", cyc, got_grnt(), exp_grnt());
      end
      total++;
      if (bif.bus_busy !== (m_owner >= 0)) begin
        bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bif.bus_busy, (m_owner >= 0));
      end
      total++;
      if ($countones(~got_grnt()) > 1) begin
        bad++; $display("FAIL rnd_overlap cyc=%0d got=%b exp=at most one low", cyc, got_grnt());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_n = 4'hF; as_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_preempt();
    test_preempt_blocked();
    test_sole_owner();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Four-master round-robin arbiter for the shared system bus.
- Produces the active-low grant lines that steer the master-side bus multiplexer.
- Guarantees at most one grant at any time.
- Fairness: a master holding the bus past a configurable limit is preempted, but only between bus cycles (address strobe idle), never mid-transaction.

Parameters:
- MAX_HOLD, 16, consecutive owned cycles before preemption is allowed; 0 disables preemption.
- CNT_W, 5, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req_  in  1  master 0 bus request, active-low.
- m1_req_  in  1  master 1 bus request, active-low.
- m2_req_  in  1  master 2 bus request, active-low.
- m3_req_  in  1  master 3 bus request, active-low.
- s_as_  in  1  muxed address strobe from the granted master, active-low; low = bus cycle in progress.
- m0_grnt_  out  1  master 0 grant, active-low, registered.
- m1_grnt_  out  1  master 1 grant, active-low, registered.
- m2_grnt_  out  1  master 2 grant, active-low, registered.
- m3_grnt_  out  1  master 3 grant, active-low, registered.
- bus_busy  out  1  active-high; 1 while any grant is asserted.

Behaviour:
- Reset: synchronous, active-high. All mN_grnt_=1, bus_busy=0, state=IDLE, owner=0, hold_cnt=0, last_owner=3 (so master 0 has first priority). Reset mid-transaction drops the grant on the next edge regardless of s_as_.
- State IDLE:
  - If no requests, remain in IDLE.
  - Otherwise select the first requester scanning last_owner+1, +2, +3, +4 (mod 4).
  - On the next edge: set owner, drive that grant low, hold_cnt=0, go to GRANT.
  - Latency is 1 cycle: req_ low sampled at edge N gives grant low after edge N.
- State GRANT: hold_cnt increments each cycle and saturates at MAX_HOLD.
- Release: owner's req_ high at an edge.
  - If another master requests, it is selected by round-robin from owner+1 and its grant goes low on the same edge the old grant goes high. No dead cycle; grants never overlap.
  - Otherwise go to IDLE with all grants high.
  - In both cases last_owner = old owner.
- Preemption: when hold_cnt==MAX_HOLD, MAX_HOLD!=0, s_as_==1 and any other master requests:
  - Switch to the next round-robin requester, excluding the owner.
  - hold_cnt resets to 0.
  - The preempted master must re-request and waits its turn.
- Preemption is blocked while s_as_==0; it fires at the first edge where s_as_==1.
- Owner is the only requester: no preemption. hold_cnt stays saturated and the grant is kept.
- Simultaneous release and new requests: handled as release; round-robin starts at owner+1.
- Invariant: at most one mN_grnt_ is low in every cycle. bus_busy equals the OR of the inverted grants.
- Width rule: round-robin index arithmetic is 2-bit modulo 4.

Decomposition:
- Shared header (alongside the bus defines) gets:
  - BUS_OWNER_W=2 and owner codes BUS_OWNER_M0..M3.
  - Arbiter state encodings ARB_IDLE and ARB_GRANT.
  - Reuse the existing ENABLE_/DISABLE_ active-low constants.
- One natural sub-module, rr_pick4 (combinational):
  - Inputs: a 4-bit request vector (active-high internally) and a 2-bit start index.
  - Outputs: the selected index and a valid flag.
  - Used for both the IDLE selection and the handover selection, with the owner masked out for preemption.

Test Plan:
- Reset with all req_=1 -> all grnt_=1, bus_busy=0. Then m2_req_=0 at edge 5 -> m2_grnt_=0 after edge 5, bus_busy=1.
- Reset, then all four req_=0 held, each master releasing after 3 cycles -> grant order 0,1,2,3,0 with zero-gap handovers and never two grants low.
- MAX_HOLD=4: m0 owns with s_as_=1, m1 requests -> m0_grnt_ rises and m1_grnt_ falls at the edge where hold_cnt reached 4.
- Same setup but s_as_=0 for 10 cycles -> no preemption until the first edge with s_as_=1.
- m3 sole requester for 40 cycles with MAX_HOLD=4 -> m3_grnt_ stays low throughout, hold_cnt saturates at 4.
- Reset asserted while m1 owns with s_as_=0 -> all grnt_=1 after that edge. After reset release with m0 and m1 requesting, m0 is granted first.
